// File: rtl/rf_pkg.sv
// Shared register-file constants and writeback sequencer state encoding.
package rf_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/regfile_wb_sequencer_arbiter.sv
// Combinational requester arbiter: round-robin from ptr by default,
// lowest-index fixed priority when WB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx
);
  logic w_found;

  always_comb begin
    grant   = '0;
    idx     = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
`ifdef WB_FIXED_PRIO_EN
      j = k;
`else
      // Rotate the search so the requester at ptr is examined first.
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
      if (!w_found && valid[j]) begin
        w_found  = 1'b1;
        grant[j] = 1'b1;
        idx      = PTR_W'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_sequencer.sv
// Register-file write-port owner: clears x1..x(NUM_REGS-1) after reset, then
// arbitrates writeback requesters. Optional macro: WB_FIXED_PRIO_EN.
module regfile_wb_sequencer #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = rf_pkg::XLEN,
  parameter int REG_ADDR_W = rf_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = rf_pkg::NUM_REGS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]      req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_rd,
  output logic [XLEN-1:0]              rf_wdata,
  output logic                         init_done
);
  import rf_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [0:0]            r_state;
  logic [REG_ADDR_W-1:0] r_clr_idx;
  logic [NUM_REQ-1:0]    w_grant;
  logic [PTR_W-1:0]      w_gidx;
  logic [PTR_W-1:0]      w_ptr;
  logic [PTR_W-1:0]      w_ptr_next;
  logic [REG_ADDR_W-1:0] w_g_rd;
  logic [XLEN-1:0]       w_g_data;
  logic                  w_xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .valid (req_valid),
    .ptr   (w_ptr),
    .grant (w_grant),
    .idx   (w_gidx)
  );

  assign w_g_rd     = req_rd[int'(w_gidx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_g_data   = req_data[int'(w_gidx)*XLEN +: XLEN];
  assign w_xfer     = (r_state == ST_RUN) && (|w_grant);
  assign req_ready  = (r_state == ST_RUN) ? w_grant : '0;
  assign w_ptr_next = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

`ifdef WB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_rr_ptr <= '0;
    else if (w_xfer) r_rr_ptr <= w_ptr_next;
  end

  assign w_ptr = r_rr_ptr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_INIT;
      r_clr_idx <= REG_ADDR_W'(1);
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      rf_we     <= 1'b1;
      rf_rd     <= r_clr_idx;
      rf_wdata  <= '0;
      r_clr_idx <= r_clr_idx + 1'b1;
      if (r_clr_idx == REG_ADDR_W'(NUM_REGS - 1)) begin
        r_state   <= ST_RUN;
        init_done <= 1'b1;
      end
    end else if (w_xfer) begin
      // x0 writes complete the handshake but never reach the file.
      rf_we    <= (w_g_rd != '0);
      rf_rd    <= w_g_rd;
      rf_wdata <= w_g_data;
    end else begin
      rf_we <= 1'b0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Directed testbench for regfile_wb_sequencer (default 3 requesters, 32x32 file).
module tb_regfile_wb_sequencer;
  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*AW-1:0]   req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rf_we;
  logic [AW-1:0]           rf_rd;
  logic [XLEN-1:0]         rf_wdata;
  logic                    init_done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [XLEN-1:0] rf_model [32];

  regfile_wb_sequencer #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one edge, sample 1 time unit later, and mirror any file write.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) rf_model[rf_rd] = rf_wdata;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] d);
    req_valid[i]            = v;
    req_rd[i*AW +: AW]      = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic run_sweep();
    for (int k = 1; k <= 31; k++) begin
      check($sformatf("init_ready_c%0d", k), {61'b0, req_ready}, 64'h0);
      tick();
      check($sformatf("init_we_c%0d", k), {63'b0, rf_we}, 64'h1);
      check($sformatf("init_rd_c%0d", k), {59'b0, rf_rd}, 64'(k));
      check($sformatf("init_wdata_c%0d", k), {32'b0, rf_wdata}, 64'h0);
      check($sformatf("init_done_c%0d", k), {63'b0, init_done}, (k == 31) ? 64'h1 : 64'h0);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_model[r] = 32'hFFFF_FFFF;
    rst = 1'b0;
    req_valid = '0; req_rd = '0; req_data = '0;
    set_req(0, 1'b1, 5'd5, 32'hAAAA_0001);
    set_req(1, 1'b1, 5'd6, 32'hBBBB_0002);
    set_req(2, 1'b1, 5'd7, 32'hCCCC_0003);
    #7;
    check("rst_we", {63'b0, rf_we}, 64'h0);
    check("rst_rd", {59'b0, rf_rd}, 64'h0);
    check("rst_wdata", {32'b0, rf_wdata}, 64'h0);
    check("rst_done", {63'b0, init_done}, 64'h0);
    check("rst_ready", {61'b0, req_ready}, 64'h0);
    #5 rst = 1'b1;

    run_sweep();
    for (int r = 1; r < 32; r++)
      check($sformatf("model_clear_x%0d", r), {32'b0, rf_model[r]}, 64'h0);

`ifndef WB_FIXED_PRIO_EN
    // Round-robin rotation with all three requesters held valid.
    check("rr_ready0", {61'b0, req_ready}, 64'h1);
    tick();
    check("rr_w0", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd5, 32'hAAAA_0001});
    check("rr_ready1", {61'b0, req_ready}, 64'h2);
    tick();
    check("rr_w1", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd6, 32'hBBBB_0002});
    check("rr_ready2", {61'b0, req_ready}, 64'h4);
    tick();
    check("rr_w2", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd7, 32'hCCCC_0003});
    check("rr_ready3", {61'b0, req_ready}, 64'h1);
    tick();
    check("rr_w3", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd5, 32'hAAAA_0001});

    // Pointer now 1: same-rd collision, requester 1 wins first.
    set_req(0, 1'b1, 5'd9, 32'h11);
    set_req(1, 1'b1, 5'd9, 32'h22);
    set_req(2, 1'b0, 5'd0, 32'h0);
    #1;
    check("col_ready0", {61'b0, req_ready}, 64'h2);
    tick();
    check("col_w0", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd9, 32'h22});
    set_req(1, 1'b0, 5'd0, 32'h0);
    #1;
    check("col_ready1", {61'b0, req_ready}, 64'h1);
    tick();
    check("col_w1", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd9, 32'h11});
    check("col_model_x9", {32'b0, rf_model[9]}, 64'h11);

    // Idle: we drops, rd/wdata hold.
    set_req(0, 1'b0, 5'd0, 32'h0);
    #1;
    check("idle_ready", {61'b0, req_ready}, 64'h0);
    tick();
    check("idle_out", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b0, 5'd9, 32'h11});

    // Pointer 1: requester 2 writes x0, dropped but accepted.
    set_req(2, 1'b1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("x0_ready", {61'b0, req_ready}, 64'h4);
    tick();
    check("x0_we", {63'b0, rf_we}, 64'h0);
    check("x0_model", {32'b0, rf_model[0]}, 64'hFFFF_FFFF);
    set_req(2, 1'b0, 5'd0, 32'h0);
    set_req(0, 1'b1, 5'd10, 32'h33);
    set_req(1, 1'b1, 5'd11, 32'h44);
    #1;
    check("x0_wrap_ready", {61'b0, req_ready}, 64'h1);
    tick();
    check("x0_wrap_w", {27'b0, rf_we, rf_rd, rf_wdata}, {27'b0, 1'b1, 5'd10, 32'h33});

    // Only requester 1 valid: granted every cycle.
    set_req(0, 1'b0, 5'd0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      set_req(1, 1'b1, 5'(12 + n), 32'(32'h50 + n));
      #1;
      check($sformatf("b2b_ready%0d", n), {61'b0, req_ready}, 64'h2);
      tick();
      check($sformatf("b2b_w%0d", n), {27'b0, rf_we, rf_rd, rf_wdata},
            {27'b0, 1'b1, 5'(12 + n), 32'(32'h50 + n)});
    end
`else
    // Fixed priority: requester 0 always beats requester 2.
    set_req(1, 1'b0, 5'd0, 32'h0);
    for (int n = 0; n < 4; n++) begin
      set_req(0, 1'b1, 5'(12 + n), 32'(32'h70 + n));
      set_req(2, 1'b1, 5'd20, 32'h99);
      #1;
      check($sformatf("fp_ready%0d", n), {61'b0, req_ready}, 64'h1);
      tick();
      check($sformatf("fp_w%0d", n), {27'b0, rf_we, rf_rd, rf_wdata},
            {27'b0, 1'b1, 5'(12 + n), 32'(32'h70 + n)});
    end
    check("fp_x20_untouched", {32'b0, rf_model[20]}, 64'h0);
`endif

    // Mid-stream asynchronous reset with a write on the outputs.
    set_req(0, 1'b1, 5'd3, 32'h77);
    set_req(1, 1'b1, 5'd4, 32'h88);
    set_req(2, 1'b1, 5'd8, 32'h66);
    tick();
    check("pre_rst_we", {63'b0, rf_we}, 64'h1);
    #1 rst = 1'b0;
    #1;
    check("async_rst_we", {63'b0, rf_we}, 64'h0);
    check("async_rst_done", {63'b0, init_done}, 64'h0);
    check("async_rst_ready", {61'b0, req_ready}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    run_sweep();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Owns the single write port of the 32x32 integer register file.
- After reset, sweeps x1..x31 to zero, because the file's storage has no reset.
- Then arbitrates NUM_REQ writeback requesters (ALU, load unit, CSR/misc) onto that port with a valid/ready handshake and round-robin fairness.
- Sits between the execute/memory writeback sources and the register file write inputs.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width.
- REG_ADDR_W, 5, register index width.
- NUM_REGS, 32, register count; the sweep covers 1..NUM_REGS-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester write request.
- req_rd  in  NUM_REQ*REG_ADDR_W  destination index; requester i occupies slice i.
- req_data  in  NUM_REQ*XLEN  write data; requester i occupies slice i.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rf_we  out  1  register file writeEnable (registered).
- rf_rd  out  REG_ADDR_W  register file rd (registered).
- rf_wdata  out  XLEN  register file writeData (registered).
- init_done  out  1  high once the clear sweep has completed (registered).

Behaviour:
- Reset (rst low, asynchronous):
  - state=INIT, clr_idx=1, rr_ptr=0.
  - rf_we=0, rf_rd=0, rf_wdata=0, init_done=0.
  - req_ready=0.
  - rf_we drops immediately on reset assertion, even mid-operation; no partial write completes.
- INIT state:
  - On each clk edge: rf_we<=1, rf_rd<=clr_idx, rf_wdata<=0, then clr_idx increments.
  - After the edge that registers clr_idx=NUM_REGS-1: state<=RUN, init_done<=1.
  - Default timing: writes to x1..x31 appear on the outputs in cycles 1..31 after reset release; init_done is high from cycle 31 onward; the first granted write appears in cycle 32 at the earliest.
  - req_ready is held at 0 throughout INIT.
- RUN state, arbitration (combinational):
  - Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - No valid requester means req_ready=0.
- RUN state, transfer on granted index g:
  - Next edge: rf_we<=(req_rd[g]!=0), rf_rd<=req_rd[g], rf_wdata<=req_data[g], rr_ptr<=(g+1) mod NUM_REQ.
  - Latency is 1 cycle from handshake to register-file write.
  - Throughput is 1 write per cycle.
- RUN state, idle cycle: rf_we<=0; rf_rd and rf_wdata hold their values; rr_ptr holds.
- Writes to x0: the handshake is accepted and rr_ptr advances, but rf_we stays 0. The write is dropped, not stalled.
- Same rd from several requesters in one cycle: only the granted one is written. The others wait and are written in later cycles in round-robin order, so the last writer wins in grant order.
- Requester rules:
  - req_valid, req_rd and req_data are held stable until accepted.
  - The sequencer does not check this; behaviour on a violation is undefined.
- Back-to-back requests from one requester with others idle: granted every cycle, since the pointer wraps back to it.
- No combinational path from req_* to rf_*.

Optional Feature:
- Macro: WB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest valid index always wins; rr_ptr is not implemented; all other behaviour is unchanged.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN, REG_ADDR_W, NUM_REGS constants.
  - State encoding: INIT=1'b0, RUN=1'b1.
- One sub-module: rr_arbiter (NUM_REQ).
  - Inputs: valid vector, ptr. Outputs: one-hot grant, encoded index.
  - Purely combinational.
  - Its fixed-priority variant is selected by WB_FIXED_PRIO_EN.

Test Plan:
- Release reset, hold all req_valid=1 → rf_we=1 with rf_rd=1..31 and rf_wdata=0 over cycles 1..31; req_ready=0 throughout; init_done=1 by cycle 31.
- RUN, req_valid=3'b111 held with rd=5/6/7 and data A/B/C → writes rd5, rd6, rd7, rd5… in consecutive cycles; req_ready rotates 001→010→100→001.
- RUN, only requester 2 valid with rd=0, data=0xDEADBEEF → req_ready[2]=1 for one cycle; rf_we stays 0; rr_ptr wraps to 0.
- RUN, requesters 0 and 1 both target rd=9 with data 0x11 and 0x22, rr_ptr=1 → 0x22 is written first, then 0x11; the register-file model ends with x9=0x11.
- Assert rst low mid-stream with a write pending → rf_we=0 asynchronously; on release the INIT sweep restarts from x1; no request is accepted before init_done.
- WB_FIXED_PRIO_EN defined, requesters 0 and 2 continuously valid → requester 0 is granted every cycle; requester 2 is never granted.
